gat_bram_host_if: RTL
=====================

Name: gat_bram_host_if

Overview:
- Parametrised host-side BRAM front end for the GAT accelerator.
- Replaces the fixed per-BRAM byte-address slicing with one NUM_CH-channel write engine:
  - converts 32-bit byte-addressed host writes into per-channel word writes;
  - truncates data to each BRAM's width;
  - counts words written per channel and raises load_done itself, so software no longer drives the done flags.
- Also provides a pipelined read-back path for the new-feature BRAM, with a read-valid strobe.

Parameters:
- TOP_WIDTH, 32, host data width.
- NUM_CH, 4, number of load channels (H data, node info, weight, subgraph).
- BRAM_W, 24, BRAM data width per channel; host data is truncated to the low BRAM_W bits.
- ADDR_W, 18, word-address width per channel.
- CH_W, $clog2(NUM_CH), channel select width; must be at least 1.
- FEAT_ADDR_W, 16, word-address width of the feature BRAM.
- FEAT_W, 32, feature data width.
- RD_LAT, 2, feature BRAM read latency in cycles; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write the depth register of one channel.
- cfg_ch  in  CH_W  channel written by cfg_we.
- cfg_depth  in  ADDR_W+1  number of words expected on that channel.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- wr_ch  in  CH_W  target channel.
- wr_addr  in  ADDR_W+2  byte address; bits [1:0] are ignored.
- wr_data  in  TOP_WIDTH  write data.
- bram_ena  out  NUM_CH  per-channel enable.
- bram_wea  out  NUM_CH  per-channel write enable.
- bram_addr  out  NUM_CH*ADDR_W  per-channel word addresses, packed with channel 0 at the LSBs.
- bram_din  out  NUM_CH*BRAM_W  per-channel write data, same packing.
- load_done  out  NUM_CH  channel has received its full depth.
- err_oob  out  1  sticky: a write was dropped.
- rd_req  in  1  feature read request.
- rd_addr  in  FEAT_ADDR_W+2  byte address for the read.
- feat_bram_addrb  out  FEAT_ADDR_W  feature BRAM address.
- feat_bram_dout  in  FEAT_W  feature BRAM data.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  FEAT_W  read data.

Behaviour:
- Reset: all outputs are 0. All depth registers, counters and channel states clear; every channel goes to IDLE. Reset asserted mid-load aborts the load; partially written BRAM contents are untouched.
- wr_ready = !rst && !cfg_we. A config write takes priority and stalls that cycle's host write.
- Per-channel FSM:
  - IDLE to LOADING on cfg_we with cfg_depth != 0. This loads the depth register and clears the counter and load_done.
  - cfg_we with depth 0 moves the channel to IDLE.
  - LOADING to DONE when an accepted write brings the count to depth. load_done rises in the cycle after that write.
  - DONE holds until the next cfg_we on that channel; cfg_we from DONE re-arms the channel.
- Accepted write, valid case: channel is LOADING and word address wr_addr[ADDR_W+1:2] < depth. In the next cycle, on that channel only:
  - bram_ena = bram_wea = 1;
  - bram_addr = word address;
  - bram_din = wr_data[BRAM_W-1:0];
  - the counter increments by 1.
  - Write latency is exactly 1 cycle.
- Accepted write, dropped case: channel is IDLE or DONE, word address >= depth, or wr_ch >= NUM_CH.
  - No BRAM strobe and no count change.
  - err_oob sets the next cycle and stays set until rst.
- The counter counts accepted writes, not distinct addresses. Rewriting an address still counts; software writes each word exactly once.
- Back-to-back writes are accepted every cycle with no bubble. Strobes are single-cycle per write; when no write occurs, ena and wea are 0 and addr/din hold their last values.
- Read path:
  - rd_req at cycle t: feat_bram_addrb = rd_addr[FEAT_ADDR_W+1:2], registered and stable from t+1.
  - rd_valid = 1 and rd_data = feat_bram_dout at cycle t+1+RD_LAT.
  - Fully pipelined: one request per cycle. A valid shift register of depth 1+RD_LAT preserves order.
  - feat_bram_addrb holds its value when no request is made.
  - Reset flushes in-flight reads; no rd_valid pulses appear after reset for them.
- Reads and writes are independent and may occur in the same cycle.

Test Plan:
1. Single-channel load: cfg ch0 depth=3; write byte addresses 0x0, 0x4, 0x8 with data 0xAABBCCDD, 0x1, 0x2 -> ch0 strobes at addresses 0, 1, 2 with din 0xBBCCDD, 0x1, 0x2, each 1 cycle after its write; load_done[0] rises the cycle after the 3rd write; err_oob = 0.
2. Out of range and write after done: after test 1, write ch0 addr 0x0 -> no strobe, err_oob = 1. Then cfg ch1 depth=2 and write ch1 byte addr 0x8 (word 2) -> dropped; load_done[1] stays 0.
3. Interleaved channels back to back: depth 2 on ch0–ch3; 8 consecutive writes alternating channels -> 8 strobes on consecutive cycles; each channel's load_done rises the cycle after its own 2nd write.
4. Config collision: cfg_we=1 and wr_valid=1 in the same cycle -> wr_ready = 0 that cycle and no strobe; the write completes the next cycle once cfg_we drops.
5. Feature read pipeline (RD_LAT=2): rd_req on 3 consecutive cycles at byte addresses 0x0, 0x4, 0x8 -> feat_bram_addrb = 0, 1, 2; rd_valid high for 3 consecutive cycles starting 3 cycles after the first request, with data in order.
6. Reset mid-operation: assert rst while a ch2 load is at count 1 of 4 with a read in flight -> all outputs 0; no rd_valid afterward; ch2 stays IDLE until the next cfg_we.

Source files
------------

// File: rtl/gat_bram_host_if.sv
// Host-side BRAM front end for the GAT accelerator: turns byte-addressed host
// writes into per-channel BRAM word writes and tracks per-channel load completion.
// It also pipelines feature BRAM read-back.
// Latency: write strobe 1 cycle after acceptance; read data 1+RD_LAT cycles after rd_req.
// Backpressure: wr_ready drops only for reset or a same-cycle config write; reads are never stalled.
//
// Ports (all synchronous to i_clk, i_rst synchronous active-high):
//   i_cfg_we/i_cfg_ch/i_cfg_depth   arm (depth != 0) or idle (depth == 0) one channel
//   i_wr_valid/o_wr_ready/i_wr_ch/i_wr_addr/i_wr_data   host write request
//   o_bram_ena/o_bram_wea/o_bram_addr/o_bram_din         per-channel BRAM port, ch0 at LSBs
//   o_load_done      per-channel "full depth received"
//   o_err_oob        sticky: a write was dropped
//   i_rd_req/i_rd_addr/o_feat_bram_addrb/i_feat_bram_dout/o_rd_valid/o_rd_data   feature read path
module gat_bram_host_if #(
    parameter int TOP_WIDTH   = 32,
    parameter int NUM_CH      = 4,
    parameter int BRAM_W      = 24,
    parameter int ADDR_W      = 18,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int FEAT_ADDR_W = 16,
    parameter int FEAT_W      = 32,
    parameter int RD_LAT      = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cfg_we,
    input  logic [CH_W-1:0]           i_cfg_ch,
    input  logic [ADDR_W:0]           i_cfg_depth,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [CH_W-1:0]           i_wr_ch,
    input  logic [ADDR_W+1:0]         i_wr_addr,
    input  logic [TOP_WIDTH-1:0]      i_wr_data,
    output logic [NUM_CH-1:0]         o_bram_ena,
    output logic [NUM_CH-1:0]         o_bram_wea,
    output logic [NUM_CH*ADDR_W-1:0]  o_bram_addr,
    output logic [NUM_CH*BRAM_W-1:0]  o_bram_din,
    output logic [NUM_CH-1:0]         o_load_done,
    output logic                      o_err_oob,
    input  logic                      i_rd_req,
    input  logic [FEAT_ADDR_W+1:0]    i_rd_addr,
    output logic [FEAT_ADDR_W-1:0]    o_feat_bram_addrb,
    input  logic [FEAT_W-1:0]         i_feat_bram_dout,
    output logic                      o_rd_valid,
    output logic [FEAT_W-1:0]         o_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

    state_t              r_state     [NUM_CH];
    state_t              w_state_nxt [NUM_CH];
    logic [ADDR_W:0]     r_depth     [NUM_CH];
    logic [ADDR_W:0]     r_cnt       [NUM_CH];
    logic [ADDR_W-1:0]   r_addr      [NUM_CH];
    logic [BRAM_W-1:0]   r_din       [NUM_CH];
    logic [NUM_CH-1:0]   r_stb;
    logic                r_err;
    logic [RD_LAT:0]     r_rd_vld;
    logic [FEAT_ADDR_W-1:0] r_addrb;

    logic                w_wr_acc;
    logic                w_ch_ok;
    logic [ADDR_W-1:0]   w_word;
    logic [NUM_CH-1:0]   w_hit;
    logic [NUM_CH-1:0]   w_cfg_sel;
    logic [NUM_CH-1:0]   w_last;
    logic                w_drop;
    logic                w_unused;

    // Byte-lane bits and host data above BRAM_W are architecturally ignored.
    assign w_unused = ^{i_wr_addr[1:0], i_wr_data, i_rd_addr[1:0]};

    // Config has priority: it stalls the host write in the same cycle.
    assign o_wr_ready = !i_rst && !i_cfg_we;
    assign w_wr_acc   = i_wr_valid && o_wr_ready;
    assign w_word     = i_wr_addr[ADDR_W+1:2];
    assign w_ch_ok    = {1'b0, i_wr_ch} < CH_LIM;

    // Per-channel FSM: state register
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rst) r_state[c] <= ST_IDLE;
            else       r_state[c] <= w_state_nxt[c];
        end
    end

    // Per-channel FSM: next state
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            if (w_cfg_sel[c]) begin
                // Any config write (re)arms or idles the channel regardless of current state.
                w_state_nxt[c] = (i_cfg_depth != '0) ? ST_LOADING : ST_IDLE;
            end else if (w_hit[c] && w_last[c]) begin
                w_state_nxt[c] = ST_DONE;
            end
        end
    end

    // Per-channel FSM: outputs / decode
    always_comb begin
        w_hit       = '0;
        w_cfg_sel   = '0;
        w_last      = '0;
        o_load_done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cfg_sel[c]   = i_cfg_we && (i_cfg_ch == CH_W'(c));
            w_hit[c]       = w_wr_acc && w_ch_ok && (i_wr_ch == CH_W'(c)) &&
                             (r_state[c] == ST_LOADING) && ({1'b0, w_word} < r_depth[c]);
            w_last[c]      = (r_cnt[c] + (ADDR_W+1)'(1)) == r_depth[c];
            o_load_done[c] = (r_state[c] == ST_DONE);
        end
    end

    // Any accepted write that does not land on a loading channel in range is dropped.
    assign w_drop = w_wr_acc && !(|w_hit);

    // Write datapath, depth and counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stb <= '0;
            r_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_depth[c] <= '0;
                r_cnt[c]   <= '0;
                r_addr[c]  <= '0;
                r_din[c]   <= '0;
            end
        end else begin
            r_stb <= w_hit;
            if (w_drop) r_err <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_cfg_sel[c]) begin
                    r_depth[c] <= i_cfg_depth;
                    r_cnt[c]   <= '0;
                end else if (w_hit[c]) begin
                    // Counts accepted writes, not distinct addresses.
                    r_cnt[c] <= r_cnt[c] + (ADDR_W+1)'(1);
                end
                // Address/data hold their last values between strobes.
                if (w_hit[c]) begin
                    r_addr[c] <= w_word;
                    r_din[c]  <= i_wr_data[BRAM_W-1:0];
                end
            end
        end
    end

    always_comb begin
        o_bram_addr = '0;
        o_bram_din  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_bram_addr[c*ADDR_W +: ADDR_W] = r_addr[c];
            o_bram_din[c*BRAM_W +: BRAM_W]  = r_din[c];
        end
    end

    assign o_bram_ena = r_stb;
    assign o_bram_wea = r_stb;
    assign o_err_oob  = r_err;

    // Read path: bit k of r_rd_vld marks a request issued k+1 cycles ago, so the
    // top bit lines up with BRAM data RD_LAT cycles after the address register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_vld <= '0;
            r_addrb  <= '0;
        end else begin
            r_rd_vld <= {r_rd_vld[RD_LAT-1:0], i_rd_req};
            if (i_rd_req) r_addrb <= i_rd_addr[FEAT_ADDR_W+1:2];
        end
    end

    assign o_feat_bram_addrb = r_addrb;
    assign o_rd_valid        = r_rd_vld[RD_LAT];
    // Gate data so it reads 0 when not valid (and therefore during/after reset).
    assign o_rd_data         = r_rd_vld[RD_LAT] ? i_feat_bram_dout : '0;

endmodule
